// File: rtl/vga_pattern_pkg.sv
// rtl/vga_pattern_pkg.sv - shared pattern codes, UART command bytes and request decode
package vga_pattern_pkg;

  localparam int PAT_W = 3;

  typedef enum logic [PAT_W-1:0] {
    PAT_BLACK = 3'd0,
    PAT_RED   = 3'd1,
    PAT_GREEN = 3'd2,
    PAT_BLUE  = 3'd3,
    PAT_WHITE = 3'd4
  } pattern_e;

  localparam logic [7:0] CMD_DIGIT_BASE = 8'h30;
  localparam logic [7:0] CMD_AUTO       = 8'h41;
  localparam logic [7:0] CMD_MANUAL     = 8'h4D;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic             valid;
    logic [PAT_W-1:0] code;
  } pat_req_t;

  // ASCII '0'..'7' maps to a pattern code; codes beyond the configured count are dropped
  function automatic pat_req_t decode_digit(input logic [7:0] rx_byte, input int num_patterns);
    pat_req_t req;
    req.code  = rx_byte[PAT_W-1:0];
    req.valid = (rx_byte[7:3] == CMD_DIGIT_BASE[7:3]) &&
                (int'(rx_byte[2:0]) < num_patterns);
    return req;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// rtl/vga_edge_detect.sv - one-bit registered rise/fall detector, history loads live input on reset
module vga_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  // History register; during reset it tracks the live input so no edge fires right after reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      d_q <= d_i;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - frame-synchronous pattern selector (auto-cycle via PATTERN_AUTO_CYCLE_EN)
module vga_pattern_sequencer
  import vga_pattern_pkg::*;
#(
  parameter int NUM_PATTERNS    = 5,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_V_Sync,
  input  logic             i_SW1,
  input  logic             i_SW2,
  input  logic             i_SW3,
  input  logic             i_SW4,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte,
  output logic [PAT_W-1:0] o_Pattern,
  output logic             o_Pending,
  output logic             o_Auto
);

  seq_state_e       state_q;
  logic [PAT_W-1:0] pattern_q;
  logic [PAT_W-1:0] pend_code_q;

  logic       frame_start;
  logic       unused_vs_rise;
  logic [3:0] sw_level;
  logic [3:0] sw_rise;
  logic [3:0] unused_sw_fall;

  pat_req_t uart_req;
  pat_req_t sw_req;
  pat_req_t req_d;

  // Falling edge of vertical sync marks the frame boundary
  vga_edge_detect u_vsync_edge (
    .clk_i   (CLK),
    .reset_i (i_Reset),
    .d_i     (i_V_Sync),
    .rise_o  (unused_vs_rise),
    .fall_o  (frame_start)
  );

  assign sw_level = {i_SW4, i_SW3, i_SW2, i_SW1};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw_edge
    vga_edge_detect u_sw_edge (
      .clk_i   (CLK),
      .reset_i (i_Reset),
      .d_i     (sw_level[gi]),
      .rise_o  (sw_rise[gi]),
      .fall_o  (unused_sw_fall[gi])
    );
  end

  // Merge requesters: a valid UART digit wins, otherwise the lowest-numbered switch edge
  always_comb begin
    uart_req       = decode_digit(i_RX_Byte, NUM_PATTERNS);
    uart_req.valid = uart_req.valid & i_RX_DV;
    sw_req         = '0;
    for (int i = 3; i >= 0; i--) begin
      if (sw_rise[i]) begin
        sw_req.valid = 1'b1;
        sw_req.code  = PAT_W'(i + 1);
      end
    end
    req_d = uart_req.valid ? uart_req : sw_req;
  end

`ifdef PATTERN_AUTO_CYCLE_EN
  localparam logic [9:0] LAST_FRAME = 10'(FRAMES_PER_STEP - 1);

  logic             auto_q;
  logic             auto_d;
  logic [9:0]       frame_cnt_q;
  logic [PAT_W-1:0] step_d;

  // Mode commands from the UART and the next code in the auto-cycle sequence
  always_comb begin
    auto_d = auto_q;
    if (i_RX_DV && (i_RX_Byte == CMD_AUTO)) begin
      auto_d = 1'b1;
    end else if (i_RX_DV && (i_RX_Byte == CMD_MANUAL)) begin
      auto_d = 1'b0;
    end
    if (int'(pattern_q) >= NUM_PATTERNS - 1) begin
      step_d = PAT_BLACK;
    end else begin
      step_d = pattern_q + PAT_W'(1);
    end
  end

  assign o_Auto = auto_q;
`else
  logic unused_fps_cfg;
  assign unused_fps_cfg = (FRAMES_PER_STEP == 0);
  assign o_Auto         = 1'b0;
`endif

  // Pending-request FSM: commit at a frame boundary, then latch any request from this same cycle
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      pattern_q   <= PAT_BLACK;
      pend_code_q <= PAT_BLACK;
`ifdef PATTERN_AUTO_CYCLE_EN
      auto_q      <= 1'b0;
      frame_cnt_q <= '0;
`endif
    end else begin
      if (frame_start) begin
        if (state_q == ST_PENDING) begin
          pattern_q <= pend_code_q;
          state_q   <= ST_IDLE;
`ifdef PATTERN_AUTO_CYCLE_EN
          if (auto_q) begin
            frame_cnt_q <= '0;
          end
`endif
        end
`ifdef PATTERN_AUTO_CYCLE_EN
        else if (auto_q) begin
          if (frame_cnt_q == LAST_FRAME) begin
            pattern_q   <= step_d;
            frame_cnt_q <= '0;
          end else begin
            frame_cnt_q <= frame_cnt_q + 10'd1;
          end
        end
`endif
      end
      // A request in a boundary cycle overrides the return to IDLE above
      if (req_d.valid) begin
        state_q     <= ST_PENDING;
        pend_code_q <= req_d.code;
      end
`ifdef PATTERN_AUTO_CYCLE_EN
      auto_q <= auto_d;
`endif
    end
  end

  assign o_Pattern = pattern_q;
  assign o_Pending = (state_q == ST_PENDING);

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb/tb_vga_pattern_sequencer.sv - self-checking bench for vga_pattern_sequencer (honours PATTERN_AUTO_CYCLE_EN)
module tb_vga_pattern_sequencer;

  localparam int NUM = 5;
  localparam int FPS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs;
  logic [3:0] sw;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [2:0] pat;
  logic       pend;
  logic       auto_o;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(
    .NUM_PATTERNS    (NUM),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .CLK       (clk),
    .i_Reset   (rst),
    .i_V_Sync  (vs),
    .i_SW1     (sw[0]),
    .i_SW2     (sw[1]),
    .i_SW3     (sw[2]),
    .i_SW4     (sw[3]),
    .i_RX_DV   (rx_dv),
    .i_RX_Byte (rx_byte),
    .o_Pattern (pat),
    .o_Pending (pend),
    .o_Auto    (auto_o)
  );

  int errors = 0;
  int checks = 0;

  int       m_pat;
  int       m_pcode;
  int       m_cnt;
  bit       m_pend;
  bit       m_auto;
  bit       m_prev_vs;
  bit [3:0] m_prev_sw;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit found;
    int code;
    if (rst) begin
      m_pat = 0; m_pcode = 0; m_pend = 0; m_auto = 0; m_cnt = 0;
    end else begin
      found = 0;
      code  = 0;
      if (rx_dv && rx_byte >= 8'h30 && rx_byte <= 8'h37 && (int'(rx_byte) - 48) < NUM) begin
        found = 1;
        code  = int'(rx_byte) - 48;
      end else begin
        for (int n = 0; n < 4; n++) begin
          if (!found && sw[n] && !m_prev_sw[n]) begin
            found = 1;
            code  = n + 1;
          end
        end
      end
      if (m_prev_vs && !vs) begin
        if (m_pend) begin
          m_pat  = m_pcode;
          m_pend = 0;
          if (m_auto) m_cnt = 0;
        end else if (m_auto) begin
          if (m_cnt == FPS - 1) begin
            m_pat = (m_pat + 1) % NUM;
            m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      if (found) begin
        m_pend  = 1;
        m_pcode = code;
      end
`ifdef PATTERN_AUTO_CYCLE_EN
      if (rx_dv && rx_byte == 8'h41) m_auto = 1;
      else if (rx_dv && rx_byte == 8'h4D) m_auto = 0;
`endif
    end
    m_prev_vs = vs;
    m_prev_sw = sw;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("pattern", int'(pat), m_pat);
    chk("pending", int'(pend), int'(m_pend));
    chk("auto", int'(auto_o), int'(m_auto));
  endtask

  task automatic boundary();
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  task automatic pin(input string name, input int exp_pat, input int exp_pend);
    chk({name, "_dut_pattern"}, int'(pat), exp_pat);
    chk({name, "_dut_pending"}, int'(pend), exp_pend);
    chk({name, "_model_pattern"}, m_pat, exp_pat);
    chk({name, "_model_pending"}, int'(m_pend), exp_pend);
  endtask

  int exp_auto [5] = '{1, 2, 3, 4, 0};
  int gap;
  int r;

  initial begin
    rst = 1'b1; vs = 1'b1; sw = 4'b0010; rx_dv = 1'b0; rx_byte = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();
    pin("reset_sw2_held", 0, 0);
    step();
    pin("sw2_still_held", 0, 0);
    sw = 4'b0000;
    step();

    sw[2] = 1'b1;
    step();
    pin("sw3_request", 0, 1);
    sw[2] = 1'b0;
    step();
    step();
    pin("sw3_waits_frame", 0, 1);
    vs = 1'b0;
    step();
    pin("sw3_commit", 3, 0);
    vs = 1'b1;
    step();

    rx_dv = 1'b1; rx_byte = 8'h34; sw[0] = 1'b1;
    step();
    rx_dv = 1'b0;
    pin("uart_beats_sw", 3, 1);
    sw[0] = 1'b0;
    step();
    boundary();
    pin("uart4_commit", 4, 0);

    rx_dv = 1'b1; rx_byte = 8'h31;
    step();
    rx_dv = 1'b0;
    pin("req1_pending", 4, 1);
    vs = 1'b0; rx_dv = 1'b1; rx_byte = 8'h32;
    step();
    rx_dv = 1'b0;
    pin("coincident_boundary", 1, 1);
    vs = 1'b1;
    step();
    boundary();
    pin("second_commit", 2, 0);

    rx_dv = 1'b1; rx_byte = 8'h37;
    step();
    rx_byte = 8'h5A;
    step();
    rx_dv = 1'b0;
    pin("ignored_bytes", 2, 0);
    boundary();
    pin("ignored_no_commit", 2, 0);

    rx_dv = 1'b1; rx_byte = 8'h33;
    step();
    rx_dv = 1'b0;
    pin("req3_pending", 2, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    pin("reset_discards", 0, 0);
    boundary();
    pin("nothing_after_reset", 0, 0);

    rx_dv = 1'b1; rx_byte = 8'h41;
    step();
    rx_dv = 1'b0;
`ifdef PATTERN_AUTO_CYCLE_EN
    chk("auto_on", int'(auto_o), 1);
`else
    chk("auto_tied_low", int'(auto_o), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      boundary();
`ifdef PATTERN_AUTO_CYCLE_EN
      pin("auto_half_step", (i == 0) ? 0 : exp_auto[i - 1], 0);
`else
      pin("auto_half_step", 0, 0);
`endif
      boundary();
`ifdef PATTERN_AUTO_CYCLE_EN
      pin("auto_step", exp_auto[i], 0);
`else
      pin("auto_step", 0, 0);
`endif
    end
    rx_dv = 1'b1; rx_byte = 8'h4D;
    step();
    rx_dv = 1'b0;
    chk("auto_off", int'(auto_o), 0);
    for (int i = 0; i < 4; i++) boundary();
    pin("manual_holds", 0, 0);

    gap = 8;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      vs  = (gap >= 2);
      if (gap == 0) gap = $urandom_range(4, 30);
      else gap = gap - 1;
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 11) == 0) sw[n] = ~sw[n];
      end
      rx_dv = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      if (r < 6)       rx_byte = 8'h30 + 8'($urandom_range(0, 7));
      else if (r == 6) rx_byte = 8'h41;
      else if (r == 7) rx_byte = 8'h4D;
      else             rx_byte = 8'($urandom_range(0, 255));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
